// File: rtl/bus_tmo_pkg.sv
// Shared constants and status-word packing for the bus timeout monitor.
package bus_tmo_pkg;

    localparam logic [3:0]  TMO_REG_OFS  = 4'b1000;
    localparam int unsigned FLT_BIT      = 31;
    localparam int unsigned FWE_BIT      = 30;
    localparam int unsigned IEN_BIT      = 29;
    localparam int unsigned OVF_BIT      = 28;
    localparam int unsigned FADR_W       = 22;
    localparam int unsigned TMO_IRQ_LINE = 14;

    function automatic logic [31:0] pack_status(input logic              flt,
                                                input logic              fwe,
                                                input logic              ien,
                                                input logic              ovf,
                                                input logic [FADR_W-1:0] fadr);
        logic [31:0] word;
        word              = '0;
        word[FLT_BIT]     = flt;
        word[FWE_BIT]     = fwe;
        word[IEN_BIT]     = ien;
        word[OVF_BIT]     = ovf;
        word[FADR_W-1:0]  = fadr;
        return word;
    endfunction

endpackage

// File: rtl/bus_tmo_if.sv
// CPU-side bus, decoder mux side and status-register port of the timeout monitor.
interface bus_tmo_if;
    import bus_tmo_pkg::*;

    logic              bus_stb;
    logic              bus_we;
    logic [FADR_W-1:0] bus_addr;
    logic              mux_ack;
    logic [31:0]       mux_din;
    logic              cpu_ack;
    logic [31:0]       cpu_din;
    logic              stb;
    logic              we;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              ack;
    logic              irq;

    modport master (
        output bus_stb, bus_we, bus_addr, mux_ack, mux_din, stb, we, data_in,
        input  cpu_ack, cpu_din, data_out, ack, irq
    );

    modport slave (
        input  bus_stb, bus_we, bus_addr, mux_ack, mux_din, stb, we, data_in,
        output cpu_ack, cpu_din, data_out, ack, irq
    );

endinterface

// File: rtl/tmo_cnt.sv
// Wait-cycle counter: clear dominates increment; tc_o flags the last allowed stall cycle.
module tmo_cnt #(
    parameter int unsigned Limit = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned Width = $clog2(Limit);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == Width'(Limit - 1));

endmodule

// File: rtl/bus_tmo.sv
// Bus timeout monitor: forces an ack with zero data on stalled cycles and logs the fault.
module bus_tmo
    import bus_tmo_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    bus_tmo_if.slave   bus
);

    logic              inc, tc, clr, force_ack;
    logic              wr, w1c, capture;
    logic              flt_d, flt_q;
    logic              fwe_d, fwe_q;
    logic              ien_d, ien_q;
    logic              ovf_d, ovf_q;
    logic [FADR_W-1:0] fadr_d, fadr_q;
    logic              irq_d, irq_q;
    logic              unused_data;

    assign inc       = bus.bus_stb & ~bus.mux_ack;
    assign force_ack = inc & tc & ~rst_i;
    assign clr       = ~bus.bus_stb | bus.mux_ack | force_ack;

    tmo_cnt #(
        .Limit (TIMEOUT)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr),
        .inc_i (inc),
        .tc_o  (tc)
    );

    assign bus.cpu_ack = bus.mux_ack | force_ack;
    assign bus.cpu_din = force_ack ? 32'h0 : bus.mux_din;

    assign wr      = bus.stb & bus.we;
    assign w1c     = wr & bus.data_in[FLT_BIT];
    // A W1C colliding with a new fault restarts logging from this fault.
    assign capture = force_ack & (~flt_q | w1c);

    always_comb begin
        flt_d  = flt_q;
        fwe_d  = fwe_q;
        ien_d  = ien_q;
        ovf_d  = ovf_q;
        fadr_d = fadr_q;
        if (w1c) begin
            flt_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (force_ack) begin
            flt_d = 1'b1;
            if (flt_q && !w1c) begin
                ovf_d = 1'b1;
            end
        end
        if (capture) begin
            fwe_d  = bus.bus_we;
            fadr_d = bus.bus_addr;
        end
        if (wr) begin
            ien_d = bus.data_in[IEN_BIT];
        end
        irq_d = flt_d & ien_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flt_q  <= 1'b0;
            fwe_q  <= 1'b0;
            ien_q  <= 1'b0;
            ovf_q  <= 1'b0;
            fadr_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flt_q  <= flt_d;
            fwe_q  <= fwe_d;
            ien_q  <= ien_d;
            ovf_q  <= ovf_d;
            fadr_q <= fadr_d;
            irq_q  <= irq_d;
        end
    end

    assign bus.ack      = bus.stb;
    assign bus.data_out = bus.stb ? pack_status(flt_q, fwe_q, ien_q, ovf_q, fadr_q) : 32'h0;
    assign bus.irq      = irq_q;

    assign unused_data = ^{bus.data_in[30], bus.data_in[28:0]};

endmodule

// File: doc/bus_tmo.md
# bus_tmo

Bus timeout monitor between the address decoder's data/acknowledge multiplexers and the CPU. Any strobed bus cycle left unacknowledged for TIMEOUT consecutive clocks is terminated with a forced acknowledge and zero read data, so the CPU never hangs on unmapped addresses or stuck devices. The faulting word address and direction are captured in a status register in I/O space at 0xFFFFE0 (word offset 4'b1000). The block raises an optional interrupt on bus_irq[14].

## Interface
- TIMEOUT, 256: consecutive unacknowledged strobe cycles before the forced acknowledge; legal range 2..65535.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  system reset. One clock; reset is synchronous and active-high.
- bus_stb  in  1  CPU bus strobe.
- bus_we  in  1  CPU bus write enable.
- bus_addr  in  22  CPU word address [23:2].
- mux_ack  in  1  acknowledge from the decoder's ack multiplexer.
- mux_din  in  32  read data from the decoder's data multiplexer.
- cpu_ack  out  1  acknowledge to the CPU.
- cpu_din  out  32  read data to the CPU.
- stb  in  1  status register strobe: i_o_stb and bus_addr[5:2]==4'b1000.
- we  in  1  register write enable (bus_we).
- data_in  in  32  register write data (bus_dout).
- data_out  out  32  register read data, fed into the decoder data multiplexer.
- ack  out  1  register acknowledge, fed into the decoder ack multiplexer.
- irq  out  1  interrupt request.

## Operation
- Counter cnt, width clog2(TIMEOUT), reset 0.
  - Increments in every cycle with bus_stb=1 and mux_ack=0.
  - Cleared in any cycle with bus_stb=0, mux_ack=1, or a forced acknowledge.
- Forced acknowledge: force = bus_stb & ~mux_ack & (cnt == TIMEOUT-1) & ~rst.
  - The force fires combinationally, in the TIMEOUT-th consecutive unacknowledged strobe cycle.
- cpu_ack = mux_ack | force.
- cpu_din = force ? 0 : mux_din.
- Writes that time out are dropped; the device receives nothing further from this block.
- Status register fields:
  - bit31 FLT: sticky fault.
  - bit30 FWE: the faulting cycle was a write.
  - bit29 IEN: interrupt enable.
  - bit28 OVF: a second fault occurred while FLT=1.
  - bits21:0 FADR: faulting word address.
  - All other bits read 0.
- On force with FLT=0: FLT←1, FWE←bus_we, FADR←bus_addr.
- On force with FLT=1: OVF←1; FWE and FADR keep the first fault.
- Register write (stb & we):
  - IEN←data_in[29].
  - data_in[31]=1 clears FLT and OVF (write-1-to-clear).
  - All other bits are ignored.
- Set versus clear in the same cycle (force together with a W1C write of the FLT bit): the set wins.
  - FLT=1, and the new FWE/FADR are captured.
  - OVF=0.
- Register access: ack = stb, combinational, zero wait states. data_out is driven whenever stb=1, 0 otherwise.
- irq = FLT & IEN, registered. Deasserts the cycle after FLT or IEN clears.

## Timing
- Reset values: cnt=0, FLT=FWE=IEN=OVF=0, FADR=0, irq=0.
  - cpu_ack follows mux_ack and cpu_din follows mux_din, with force suppressed while rst=1.
  - ack=0 and data_out=0 unless stb=1.
- Pass-through adds zero latency: a device ack in cycle n reaches the CPU in cycle n.
- A device ack arriving in exactly the cycle where cnt==TIMEOUT-1 is a normal ack, not a fault.
- A strobe held past a forced ack (the CPU issues back-to-back cycles) restarts counting from 0 in the next cycle.
- Reset asserted mid-transaction clears cnt in the same edge; no fault is recorded.
- irq rises one clock after the force cycle if IEN=1.
- The status register lies in the monitored space and is acknowledged in cycle 0, so it never times out.

## Structure
- Package bus_tmo_pkg holds:
  - TMO_REG_OFS = 4'b1000.
  - Bit positions FLT_BIT=31, FWE_BIT=30, IEN_BIT=29, OVF_BIT=28.
  - FADR_W = 22.
  - TMO_IRQ_LINE = 14.
- One sub-module, tmo_cnt: saturating-free wait counter with clear/inc inputs and a terminal-count output.
- The status register logic stays in bus_tmo.
- Top-level changes:
  - bus_tmo is inserted between the decoder's bus_din/bus_ack multiplexers and the CPU.
  - tmo_stb is added to both multiplexers.
  - bus_irq[14] = irq.

## Test plan
All scenarios use TIMEOUT=16.
- Normal access: bus_stb high, mux_ack after 3 cycles with mux_din=0x12345678 → cpu_ack in the same cycle, cpu_din=0x12345678, FLT stays 0.
- Timeout read: bus_stb high for 16 cycles at word address 0x3FF800, mux_ack=0 → cpu_ack=1 and cpu_din=0 in cycle 16; status reads 0x803FF800.
- Boundary: mux_ack arrives exactly in cycle 16 → no fault, cpu_din=mux_din; a 17-cycle stall is forced in cycle 16.
- Double fault and interrupt:
  - Write IEN=1.
  - Timeout write at 0x000100 → irq high one clock later; status reads 0xE0000100.
  - Second timeout at 0x000200 → OVF=1, FADR stays 0x000100.
  - W1C write 0x80000000 → FLT=OVF=0; irq drops next cycle.
- Collision: W1C write (IEN kept at 1) in the same cycle as a force at 0x000300 → FLT=1, OVF=0, FADR=0x000300.
- Reset mid-stall: rst asserted after 10 unacknowledged cycles → no force, FLT=0; after release, a fresh stall times out after a full 16 cycles.
